// File: rtl/qracc_bitserial_accumulator_if.sv
// ----------------------------------------------------------------------------
// qracc_bitserial_accumulator_if
//   Bundles the configuration, ADC bit-plane input and result handshake of the
//   bit-serial accumulator.
//
//   master : drives cfg/start/ADC planes and acc_ready_i, observes results
//   slave  : the accumulator itself
//
//   Signals
//     cfg_n_bits_i  bit-planes per accumulation (sampled on accepted start)
//     cfg_signed_i  1 = two's-complement activations (sampled on accepted start)
//     start_i       single-cycle start request
//     adc_valid_i   adc_data_i carries one bit-plane
//     adc_data_i    per-column signed ADC codes
//     busy_o        accumulation in progress or result pending
//     drop_o        one-cycle pulse for a plane that arrived outside ACCUM
//     acc_valid_o   acc_data_o is valid
//     acc_ready_i   consumer takes the result
//     acc_data_o    per-column signed results
//     sat_o         per-column clamp flags (only with QRACC_ACC_SATURATE_EN)
// ----------------------------------------------------------------------------
interface qracc_bitserial_accumulator_if #(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int maxInBits  = 8,
    parameter int accBits    = 16
);
    localparam int CNT_W = $clog2(maxInBits + 1);

    logic [CNT_W-1:0]                    cfg_n_bits_i;
    logic                                cfg_signed_i;
    logic                                start_i;
    logic                                adc_valid_i;
    logic [numCols-1:0][numAdcBits-1:0]  adc_data_i;
    logic                                busy_o;
    logic                                drop_o;
    logic                                acc_valid_o;
    logic                                acc_ready_i;
    logic [numCols-1:0][accBits-1:0]     acc_data_o;
`ifdef QRACC_ACC_SATURATE_EN
    logic [numCols-1:0]                  sat_o;

    modport master (
        output cfg_n_bits_i, cfg_signed_i, start_i, adc_valid_i, adc_data_i, acc_ready_i,
        input  busy_o, drop_o, acc_valid_o, acc_data_o, sat_o
    );
    modport slave (
        input  cfg_n_bits_i, cfg_signed_i, start_i, adc_valid_i, adc_data_i, acc_ready_i,
        output busy_o, drop_o, acc_valid_o, acc_data_o, sat_o
    );
`else
    modport master (
        output cfg_n_bits_i, cfg_signed_i, start_i, adc_valid_i, adc_data_i, acc_ready_i,
        input  busy_o, drop_o, acc_valid_o, acc_data_o
    );
    modport slave (
        input  cfg_n_bits_i, cfg_signed_i, start_i, adc_valid_i, adc_data_i, acc_ready_i,
        output busy_o, drop_o, acc_valid_o, acc_data_o
    );
`endif
endinterface

// File: rtl/qracc_bitserial_accumulator.sv
// ----------------------------------------------------------------------------
// qracc_bitserial_accumulator
//   Combines successive signed per-column ADC codes, one per activation
//   bit-plane (MSB first), by shift-add into multi-bit column results and
//   hands them downstream through a valid/ready handshake.
//
//   Ports
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   qracc_bitserial_accumulator_if.slave (cfg, start, ADC planes,
//           busy/drop status, result handshake)
//
//   Build option
//     QRACC_ACC_SATURATE_EN : clamp each column to satBits signed at the end
//                             of accumulation, flag clamped columns on sat_o.
//
//   State | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start_i
//   ACCUM | consuming one bit-plane per adc_valid_i until n_bits planes
//   OUT_WAIT | result presented, waiting for acc_ready_i
// ----------------------------------------------------------------------------
module qracc_bitserial_accumulator #(
    parameter int numCols    = 32,
    parameter int numAdcBits = 4,
    parameter int maxInBits  = 8,
    parameter int accBits    = 16
`ifdef QRACC_ACC_SATURATE_EN
    ,
    parameter int satBits    = 8
`endif
) (
    input logic                           clk,
    input logic                           rst,
    qracc_bitserial_accumulator_if.slave  bus
);

    localparam int               CNT_W = $clog2(maxInBits + 1);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(maxInBits);
    localparam int               EXT_W = accBits - numAdcBits;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        OUT_WAIT = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          n_bits_q;
    logic [CNT_W-1:0]          n_bits_cfg;
    logic                      signed_q;
    logic                      drop_q;
    logic signed [accBits-1:0] acc_q   [numCols];
    logic signed [accBits-1:0] acc_d   [numCols];
    logic signed [accBits-1:0] plane_x [numCols];
    logic                      handshake;
    logic                      start_acc;
    logic                      plane_acc;
    logic                      last_plane;
    logic                      neg_first;

`ifdef QRACC_ACC_SATURATE_EN
    localparam int                        SAT_MAX_I = (1 << (satBits - 1)) - 1;
    localparam logic signed [accBits-1:0] SAT_MAX   = accBits'(SAT_MAX_I);
    localparam logic signed [accBits-1:0] SAT_MIN   = ~SAT_MAX;

    logic signed [accBits-1:0] sat_data_q [numCols];
    logic [numCols-1:0]        sat_q;
`endif

    // Control decode shared by the FSM and the datapath.
    always_comb begin
        handshake  = (state_q == OUT_WAIT) && bus.acc_ready_i;
        // A start coinciding with the result handshake chains straight into ACCUM.
        start_acc  = bus.start_i && ((state_q == IDLE) || handshake);
        plane_acc  = (state_q == ACCUM) && bus.adc_valid_i;
        last_plane = plane_acc && (cnt_q == n_bits_q - CNT_W'(1));
        // A single-plane run is plain unsigned/signed x; the MSB weight is only
        // negative when there is more than one plane.
        neg_first  = signed_q && (n_bits_q > CNT_W'(1));
        if (bus.cfg_n_bits_i == '0) begin
            n_bits_cfg = CNT_W'(1);
        end else if (bus.cfg_n_bits_i > MAX_N) begin
            n_bits_cfg = MAX_N;
        end else begin
            n_bits_cfg = bus.cfg_n_bits_i;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = ACCUM;
            end
            ACCUM: begin
                if (last_plane) state_d = OUT_WAIT;
            end
            OUT_WAIT: begin
                if (handshake) state_d = bus.start_i ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-column shift-add.
    always_comb begin
        for (int c = 0; c < numCols; c++) begin
            plane_x[c] = {{EXT_W{bus.adc_data_i[c][numAdcBits-1]}}, bus.adc_data_i[c]};
            if (cnt_q == '0) begin
                acc_d[c] = neg_first ? -plane_x[c] : plane_x[c];
            end else begin
                acc_d[c] = (acc_q[c] <<< 1) + plane_x[c];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            n_bits_q <= '0;
            signed_q <= 1'b0;
            drop_q   <= 1'b0;
            for (int c = 0; c < numCols; c++) acc_q[c] <= '0;
        end else begin
            drop_q <= bus.adc_valid_i && (state_q != ACCUM);
            if (start_acc) begin
                cnt_q    <= '0;
                n_bits_q <= n_bits_cfg;
                signed_q <= bus.cfg_signed_i;
                for (int c = 0; c < numCols; c++) acc_q[c] <= '0;
            end else if (plane_acc) begin
                cnt_q <= cnt_q + CNT_W'(1);
                for (int c = 0; c < numCols; c++) acc_q[c] <= acc_d[c];
            end
        end
    end

`ifdef QRACC_ACC_SATURATE_EN
    // Clamp on the final plane so the registered result appears together
    // with acc_valid_o, keeping latency identical to the wrapping build.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= '0;
            for (int c = 0; c < numCols; c++) sat_data_q[c] <= '0;
        end else if (last_plane) begin
            for (int c = 0; c < numCols; c++) begin
                if (acc_d[c] > SAT_MAX) begin
                    sat_data_q[c] <= SAT_MAX;
                    sat_q[c]      <= 1'b1;
                end else if (acc_d[c] < SAT_MIN) begin
                    sat_data_q[c] <= SAT_MIN;
                    sat_q[c]      <= 1'b1;
                end else begin
                    sat_data_q[c] <= acc_d[c];
                    sat_q[c]      <= 1'b0;
                end
            end
        end
    end
`endif

    // Outputs.
    always_comb begin
        bus.busy_o      = (state_q != IDLE);
        bus.acc_valid_o = (state_q == OUT_WAIT);
        bus.drop_o      = drop_q;
        for (int c = 0; c < numCols; c++) begin
`ifdef QRACC_ACC_SATURATE_EN
            bus.acc_data_o[c] = sat_data_q[c];
`else
            bus.acc_data_o[c] = acc_q[c];
`endif
        end
`ifdef QRACC_ACC_SATURATE_EN
        bus.sat_o = sat_q;
`endif
    end

endmodule

// File: tb/tb_qracc_bitserial_accumulator.sv
module tb_qracc_bitserial_accumulator;

    localparam int NC   = 32;
    localparam int AW   = 4;
    localparam int ACW  = 16;
    localparam int MAXB = 8;
    localparam int CW   = $clog2(MAXB + 1);

    typedef logic [NC-1:0][AW-1:0]  adc_vec_t;
    typedef logic [NC-1:0][ACW-1:0] acc_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    qracc_bitserial_accumulator_if #(
        .numCols(NC), .numAdcBits(AW), .maxInBits(MAXB), .accBits(ACW)
    ) bus ();

    qracc_bitserial_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic adc_vec_t adc_fill(input logic [AW-1:0] v);
        adc_vec_t r;
        for (int c = 0; c < NC; c++) r[c] = v;
        return r;
    endfunction

    function automatic acc_vec_t acc_fill(input logic [ACW-1:0] v);
        acc_vec_t r;
        for (int c = 0; c < NC; c++) r[c] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int nb, input logic sg);
        bus.cfg_n_bits_i = CW'(nb);
        bus.cfg_signed_i = sg;
        bus.start_i      = 1'b1;
        tick();
        bus.start_i      = 1'b0;
    endtask

    task automatic plane(input adc_vec_t d);
        bus.adc_valid_i = 1'b1;
        bus.adc_data_i  = d;
        tick();
        bus.adc_valid_i = 1'b0;
        bus.adc_data_i  = '0;
    endtask

    task automatic finish_out();
        bus.acc_ready_i = 1'b1;
        tick();
        bus.acc_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.cfg_n_bits_i = '0;
        bus.cfg_signed_i = 1'b0;
        bus.start_i      = 1'b0;
        bus.adc_valid_i  = 1'b0;
        bus.adc_data_i   = '0;
        bus.acc_ready_i  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.drop_o !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", bus.drop_o); end
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== acc_vec_t'(0)) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.acc_data_o); end
`ifdef QRACC_ACC_SATURATE_EN
        n_cmp++; if (bus.sat_o !== '0) begin n_err++; $display("FAIL reset_sat: got %h want 0", bus.sat_o); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        acc_vec_t exp = acc_fill(16'd11);
        start_run(4, 1'b0);
        plane(adc_fill(4'd1));
        plane(adc_fill(4'd0));
        plane(adc_fill(4'd1));
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_err++; $display("FAIL unsigned_early_valid: got %b want 0", bus.acc_valid_o); end
        plane(adc_fill(4'd1));
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL unsigned_valid: got %b want 1", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL unsigned_data: got %h want %h", bus.acc_data_o, exp); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL unsigned_busy: got %b want 1", bus.busy_o); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL unsigned_hold_valid[%0d]: got %b want 1", i, bus.acc_valid_o); end
            n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL unsigned_hold_data[%0d]: got %h want %h", i, bus.acc_data_o, exp); end
        end
        finish_out();
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_err++; $display("FAIL unsigned_release_valid: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL unsigned_release_busy: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_signed();
        adc_vec_t p0 = '0;
        adc_vec_t pk = '0;
        acc_vec_t exp = '0;
        p0[0] = 4'h7; p0[1] = 4'h8;
        pk[0] = 4'h7;
        exp[0] = 16'hFFF9;
        exp[1] = 16'd64;
        start_run(4, 1'b1);
        plane(p0);
        plane(pk);
        plane(pk);
        plane(pk);
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL signed_valid: got %b want 1", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL signed_data: got %h want %h", bus.acc_data_o, exp); end
        finish_out();
    endtask

    task automatic test_extremes();
        acc_vec_t exp;
        start_run(8, 1'b1);
        for (int i = 0; i < 8; i++) plane(adc_fill(4'h8));
        exp = acc_fill(16'd8);
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL signed_min_data: got %h want %h", bus.acc_data_o, exp); end
        finish_out();
        start_run(8, 1'b0);
        for (int i = 0; i < 8; i++) plane(adc_fill(4'h7));
`ifdef QRACC_ACC_SATURATE_EN
        exp = acc_fill(16'd127);
        n_cmp++; if (bus.sat_o !== {NC{1'b1}}) begin n_err++; $display("FAIL unsigned_max_sat: got %h want all ones", bus.sat_o); end
`else
        exp = acc_fill(16'd1785);
`endif
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL unsigned_max_data: got %h want %h", bus.acc_data_o, exp); end
        finish_out();
    endtask

    task automatic test_back_to_back();
        acc_vec_t exp = acc_fill(16'd8);
        start_run(2, 1'b0);
        plane(adc_fill(4'd3));
        plane(adc_fill(4'd2));
        bus.adc_valid_i = 1'b1;
        bus.adc_data_i  = adc_fill(4'd5);
        tick();
        bus.adc_valid_i = 1'b0;
        bus.adc_data_i  = '0;
        n_cmp++; if (bus.drop_o !== 1'b1) begin n_err++; $display("FAIL b2b_drop: got %b want 1", bus.drop_o); end
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL b2b_data_after_drop: got %h want %h", bus.acc_data_o, exp); end
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid_after_drop: got %b want 1", bus.acc_valid_o); end
        tick();
        n_cmp++; if (bus.drop_o !== 1'b0) begin n_err++; $display("FAIL b2b_drop_single: got %b want 0", bus.drop_o); end
        bus.acc_ready_i  = 1'b1;
        bus.start_i      = 1'b1;
        bus.cfg_n_bits_i = CW'(2);
        bus.cfg_signed_i = 1'b1;
        tick();
        bus.acc_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_no_idle: got %b want 1", bus.busy_o); end
        plane(adc_fill(4'd1));
        plane(adc_fill(4'd1));
        exp = acc_fill(16'hFFFF);
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b want 1", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL b2b_second_data: got %h want %h", bus.acc_data_o, exp); end
        finish_out();
    endtask

    task automatic test_nbits_zero();
        acc_vec_t exp = acc_fill(16'hFFFD);
        bus.cfg_n_bits_i = '0;
        bus.cfg_signed_i = 1'b1;
        bus.start_i      = 1'b1;
        bus.adc_valid_i  = 1'b1;
        bus.adc_data_i   = adc_fill(4'd5);
        tick();
        bus.start_i     = 1'b0;
        bus.adc_valid_i = 1'b0;
        bus.adc_data_i  = '0;
        n_cmp++; if (bus.drop_o !== 1'b1) begin n_err++; $display("FAIL zero_start_drop: got %b want 1", bus.drop_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b want 1", bus.busy_o); end
        plane(adc_fill(4'hD));
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b want 1", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL zero_data: got %h want %h", bus.acc_data_o, exp); end
        finish_out();
    endtask

    task automatic test_rst_mid();
        acc_vec_t exp = acc_fill(16'd3);
        start_run(4, 1'b0);
        plane(adc_fill(4'd1));
        plane(adc_fill(4'd1));
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.acc_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== acc_vec_t'(0)) begin n_err++; $display("FAIL rst_mid_data: got %h want 0", bus.acc_data_o); end
        tick();
        rst = 1'b0;
        tick();
        start_run(2, 1'b0);
        plane(adc_fill(4'd1));
        plane(adc_fill(4'd1));
        n_cmp++; if (bus.acc_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_new_valid: got %b want 1", bus.acc_valid_o); end
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL rst_new_data: got %h want %h", bus.acc_data_o, exp); end
        finish_out();
    endtask

`ifdef QRACC_ACC_SATURATE_EN
    task automatic test_saturate_inrange();
        logic [7:0] bits_v;
        acc_vec_t   exp = acc_fill(16'd100);
        bits_v = 8'd100;
        start_run(8, 1'b0);
        for (int i = 7; i >= 0; i--) plane(adc_fill({3'b000, bits_v[i]}));
        n_cmp++; if (bus.acc_data_o !== exp) begin n_err++; $display("FAIL sat_inrange_data: got %h want %h", bus.acc_data_o, exp); end
        n_cmp++; if (bus.sat_o !== '0) begin n_err++; $display("FAIL sat_inrange_flag: got %h want 0", bus.sat_o); end
        finish_out();
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_back_to_back();
        test_nbits_zero();
        test_rst_mid();
`ifdef QRACC_ACC_SATURATE_EN
        test_saturate_inrange();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
